// File: rtl/branch_control_sequencer.sv
// Hardwired T0-T6 control sequencer for the branch instruction class, with memory-wait,
// NOP/HALT handling, illegal-opcode trap and memory timeout. Optional branch statistics: BRANCH_STATS_EN.
module branch_control_sequencer #(
  parameter int OPCODE_WIDTH = 5,
  parameter logic [OPCODE_WIDTH-1:0] BR_OPCODE   = 5'b10010,
  parameter logic [OPCODE_WIDTH-1:0] NOP_OPCODE  = 5'b11010,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 5'b11011,
  parameter logic [OPCODE_WIDTH-1:0] ALU_ADD     = 5'b00011,
  parameter int MEM_TIMEOUT = 16
`ifdef BRANCH_STATS_EN
  ,
  parameter int STAT_WIDTH = 16
`endif
) (
  input  logic                    Clock,
  input  logic                    clear_n,
  input  logic                    run,
  input  logic [OPCODE_WIDTH-1:0] ir_opcode,
  input  logic                    con_ff_bit,
  input  logic                    memory_done,
  output logic                    PCout,
  output logic                    IncPC,
  output logic                    MARin,
  output logic                    Zin,
  output logic                    Zlo_out,
  output logic                    PCin,
  output logic                    MDRin,
  output logic                    MDRout,
  output logic                    IRin,
  output logic                    Gra,
  output logic                    Rout,
  output logic                    CONin,
  output logic                    Yin,
  output logic                    Cout,
  output logic                    Mem_read,
  output logic                    Mem_enable512x32,
  output logic [OPCODE_WIDTH-1:0] alu_op,
  output logic                    instr_done,
  output logic                    halted,
  output logic                    fault,
  output logic [1:0]              fault_code
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]   taken_count,
  output logic [STAT_WIDTH-1:0]   not_taken_count
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_DEC,
    S_BR3, S_BR4, S_BR5, S_BR6, S_HALT, S_FAULT
  } state_t;

  state_t            r_state, w_next_state;
  logic [WAIT_W-1:0] r_wait, w_next_wait, w_wait_inc;
  logic [1:0]        r_fault_code, w_next_fault_code;

  assign w_wait_inc = r_wait + WAIT_W'(1);

  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_fault_code <= 2'b00;
    end else begin
      r_state      <= w_next_state;
      r_wait       <= w_next_wait;
      r_fault_code <= w_next_fault_code;
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_next_wait       = r_wait;
    w_next_fault_code = r_fault_code;
    case (r_state)
      S_IDLE: w_next_state = run ? S_T0 : S_IDLE;
      S_T0:   w_next_state = S_T1;
      S_T1: begin
        if (memory_done) begin
          w_next_state = S_T2;
        end else begin
          w_next_state = S_T1W;
          w_next_wait  = '0;
        end
      end
      // memory_done wins over a timeout landing in the same cycle
      S_T1W: begin
        if (memory_done) begin
          w_next_state = S_T2;
        end else if (w_wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
          w_next_wait       = w_wait_inc;
          w_next_state      = S_FAULT;
          w_next_fault_code = 2'b10;
        end else begin
          w_next_wait = w_wait_inc;
        end
      end
      S_T2: w_next_state = S_DEC;
      S_DEC: begin
        if (ir_opcode == BR_OPCODE) begin
          w_next_state = S_BR3;
        end else if (ir_opcode == NOP_OPCODE) begin
          w_next_state = run ? S_T0 : S_IDLE;
        end else if (ir_opcode == HALT_OPCODE) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state      = S_FAULT;
          w_next_fault_code = 2'b01;
        end
      end
      S_BR3:   w_next_state = S_BR4;
      S_BR4:   w_next_state = S_BR5;
      S_BR5:   w_next_state = S_BR6;
      S_BR6:   w_next_state = run ? S_T0 : S_IDLE;
      S_HALT:  w_next_state = S_HALT;
      S_FAULT: w_next_state = S_FAULT;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    {PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, MDRout} = 8'b0000_0000;
    {IRin, Gra, Rout, CONin, Yin, Cout}                      = 6'b00_0000;
    {Mem_read, Mem_enable512x32}                             = 2'b00;
    alu_op     = '0;
    instr_done = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    fault_code = r_fault_code;
    case (r_state)
      S_T0:  {PCout, IncPC, MARin, Zin} = 4'b1111;
      S_T1:  {Zlo_out, PCin, MDRin, Mem_read, Mem_enable512x32} = 5'b11111;
      S_T1W: {MDRin, Mem_read, Mem_enable512x32} = 3'b111;
      S_T2:  {MDRout, IRin} = 2'b11;
      S_DEC: instr_done = (ir_opcode == NOP_OPCODE);
      S_BR3: {Gra, Rout, CONin} = 3'b111;
      S_BR4: {PCout, Yin} = 2'b11;
      S_BR5: begin
        {Cout, Zin} = 2'b11;
        alu_op      = ALU_ADD;
      end
      // branch condition only steers PC load here
      S_BR6: begin
        Zlo_out    = 1'b1;
        PCin       = con_ff_bit;
        instr_done = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: instr_done = 1'b0;
    endcase
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_WIDTH-1:0] r_taken, r_not_taken;

  // Saturating taken / not-taken counters, bumped once per BR6
  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      r_taken     <= '0;
      r_not_taken <= '0;
    end else if (r_state == S_BR6) begin
      if (con_ff_bit) begin
        if (r_taken != {STAT_WIDTH{1'b1}}) r_taken <= r_taken + STAT_WIDTH'(1);
      end else begin
        if (r_not_taken != {STAT_WIDTH{1'b1}}) r_not_taken <= r_not_taken + STAT_WIDTH'(1);
      end
    end
  end

  assign taken_count     = r_taken;
  assign not_taken_count = r_not_taken;
`endif

endmodule

// File: tb/tb_branch_control_sequencer.sv
// Self-checking bench for branch_control_sequencer: per-instruction expected control traces
// are built from the step table and compared cycle by cycle under randomized don't-care inputs.
module tb_branch_control_sequencer;

  localparam logic [4:0] BR   = 5'b10010;
  localparam logic [4:0] NOP  = 5'b11010;
  localparam logic [4:0] HALT = 5'b11011;
  localparam logic [4:0] ADD  = 5'b00011;

  // control bit order: PCout IncPC MARin Zin Zlo PCin MDRin MDRout IRin Gra Rout CONin Yin Cout MemRd MemEn
  localparam logic [15:0] C_T0   = 16'b1111_0000_0000_0000;
  localparam logic [15:0] C_T1   = 16'b0000_1110_0000_0011;
  localparam logic [15:0] C_T1W  = 16'b0000_0010_0000_0011;
  localparam logic [15:0] C_T2   = 16'b0000_0001_1000_0000;
  localparam logic [15:0] C_BR3  = 16'b0000_0000_0111_0000;
  localparam logic [15:0] C_BR4  = 16'b1000_0000_0000_1000;
  localparam logic [15:0] C_BR5  = 16'b0001_0000_0000_0100;
  localparam logic [15:0] C_ZLO  = 16'b0000_1000_0000_0000;
  localparam logic [15:0] C_PCIN = 16'b0000_0100_0000_0000;

  typedef struct packed {
    logic [15:0] c;
    logic [4:0]  alu;
    logic        done;
    logic        h;
    logic        f;
    logic [1:0]  fc;
  } obs_t;

  logic Clock = 1'b0;
  logic clear_n, run, con_ff_bit, memory_done;
  logic [4:0] ir_opcode;
  logic PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, MDRout, IRin, Gra, Rout, CONin, Yin, Cout;
  logic Mem_read, Mem_enable512x32, instr_done, halted, fault;
  logic [4:0] alu_op;
  logic [1:0] fault_code;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count, not_taken_count;
  int m_taken, m_not;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  branch_control_sequencer dut (
    .Clock(Clock), .clear_n(clear_n), .run(run), .ir_opcode(ir_opcode),
    .con_ff_bit(con_ff_bit), .memory_done(memory_done),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .Zlo_out(Zlo_out), .PCin(PCin),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Rout(Rout), .CONin(CONin),
    .Yin(Yin), .Cout(Cout), .Mem_read(Mem_read), .Mem_enable512x32(Mem_enable512x32),
    .alu_op(alu_op), .instr_done(instr_done), .halted(halted), .fault(fault),
    .fault_code(fault_code)
`ifdef BRANCH_STATS_EN
    , .taken_count(taken_count), .not_taken_count(not_taken_count)
`endif
  );

  function automatic obs_t mk(input logic [15:0] c, input logic [4:0] a, input logic d,
                              input logic h, input logic f, input logic [1:0] fc);
    obs_t o;
    o.c = c; o.alu = a; o.done = d; o.h = h; o.f = f; o.fc = fc;
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.c = {PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, MDRout, IRin, Gra, Rout, CONin,
           Yin, Cout, Mem_read, Mem_enable512x32};
    o.alu = alu_op; o.done = instr_done; o.h = halted; o.f = fault; o.fc = fault_code;
    return o;
  endfunction

  task automatic do_reset();
    clear_n = 1'b0;
    run     = 1'b0;
    #3;
    @(posedge Clock);
    @(negedge Clock);
    clear_n = 1'b1;
    run     = 1'b1;
`ifdef BRANCH_STATS_EN
    m_taken = 0; m_not = 0;
`endif
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    obs_t o;
    clear_n = 1'b0; run = 1'b1; memory_done = 1'b1; ir_opcode = BR; con_ff_bit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      o = cur();
      n_tests++;
      if (o !== mk(16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00)) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %h want all zero", i, o);
      end
    end
    @(negedge Clock); clear_n = 1'b1;
`ifdef BRANCH_STATS_EN
    m_taken = 0; m_not = 0;
`endif
    @(posedge Clock); #1;
    o = cur();
    n_tests++;
    if (o !== mk(C_T0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00)) begin
      n_fail++;
      $display("FAIL reset_release_T0: got %h want %h", o, mk(C_T0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    end
  endtask

  // Expects T0 visible on entry; leaves T0 visible on exit for BR/NOP.
  task automatic exec(input logic [4:0] op, input logic con, input int waits,
                      input logic run_after, input string tag);
    obs_t q[$];
    obs_t o;
    int   dec_i, b6;
    logic term;
    q.push_back(mk(C_T0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    q.push_back(mk(C_T1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    repeat (waits) q.push_back(mk(C_T1W, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    q.push_back(mk(C_T2, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    dec_i = q.size();
    q.push_back(mk(16'h0000, 5'd0, op == NOP, 1'b0, 1'b0, 2'b00));
    term = !(op == BR || op == NOP);
    b6 = -1;
    if (op == BR) begin
      q.push_back(mk(C_BR3, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00));
      q.push_back(mk(C_BR4, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00));
      q.push_back(mk(C_BR5, ADD, 1'b0, 1'b0, 1'b0, 2'b00));
      b6 = q.size();
      q.push_back(mk(C_ZLO | (con ? C_PCIN : 16'h0000), 5'd0, 1'b1, 1'b0, 1'b0, 2'b00));
    end else if (op == HALT) begin
      repeat (4) q.push_back(mk(16'h0000, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00));
    end else if (op != NOP) begin
      repeat (4) q.push_back(mk(16'h0000, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01));
    end
    for (int k = 0; k < q.size(); k++) begin
      o = cur();
      n_tests++;
      if (o !== q[k]) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h want %h", tag, k, o, q[k]);
      end
      memory_done = (k >= 1 && k <= 1 + waits) ? (k == 1 + waits) : 1'($urandom);
      ir_opcode   = (k + 1 == dec_i || k == dec_i) ? op : 5'($urandom);
      con_ff_bit  = (b6 >= 0 && k + 1 == b6) ? con : 1'($urandom);
      run         = term ? 1'b1 : ((k == q.size() - 1) ? run_after : 1'($urandom));
      @(posedge Clock); #1;
    end
    if (!term) begin
`ifdef BRANCH_STATS_EN
      if (op == BR) begin
        if (con) m_taken++; else m_not++;
      end
`endif
      if (!run_after) begin
        for (int i = 0; i < 2; i++) begin
          o = cur();
          n_tests++;
          if (o !== mk(16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00)) begin
            n_fail++;
            $display("FAIL %s idle %0d: got %h want all zero", tag, i, o);
          end
          run = (i == 1);
          @(posedge Clock); #1;
        end
      end
`ifdef BRANCH_STATS_EN
      n_tests++;
      if (taken_count !== 16'(m_taken) || not_taken_count !== 16'(m_not)) begin
        n_fail++;
        $display("FAIL %s stats: got %0d/%0d want %0d/%0d", tag, taken_count, not_taken_count,
                 m_taken, m_not);
      end
`endif
    end
  endtask

  task automatic test_branch();
    exec(BR, 1'b1, 0, 1'b1, "br_taken");
    exec(BR, 1'b0, 0, 1'b1, "br_not_taken");
    exec(BR, 1'b1, 3, 1'b1, "br_wait3");
    exec(BR, 1'b0, 1, 1'b0, "br_wait1_stop");
  endtask

  task automatic test_nop();
    exec(NOP, 1'b0, 0, 1'b1, "nop_refetch");
    exec(NOP, 1'b1, 2, 1'b0, "nop_stop");
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int i = 0; i < 25; i++) begin
      op = ($urandom_range(0, 2) == 0) ? NOP : BR;
      exec(op, 1'($urandom), int'($urandom_range(0, 4)), 1'($urandom), "random");
    end
  endtask

  task automatic test_timeout();
    obs_t q[$];
    obs_t o;
    q.push_back(mk(C_T0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    q.push_back(mk(C_T1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    repeat (16) q.push_back(mk(C_T1W, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    repeat (3) q.push_back(mk(16'h0000, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10));
    for (int k = 0; k < q.size(); k++) begin
      o = cur();
      n_tests++;
      if (o !== q[k]) begin
        n_fail++;
        $display("FAIL timeout step %0d: got %h want %h", k, o, q[k]);
      end
      memory_done = (k == 0) ? 1'($urandom) : 1'b0;
      ir_opcode   = 5'($urandom);
      run         = 1'b1;
      @(posedge Clock); #1;
    end
    do_reset();
  endtask

  task automatic test_decode_traps();
    logic [4:0] op;
    exec(HALT, 1'b0, 0, 1'b1, "halt");
    do_reset();
    exec(5'b00000, 1'b0, 1, 1'b1, "illegal_00000");
    do_reset();
    do op = 5'($urandom); while (op == BR || op == NOP || op == HALT);
    exec(op, 1'b0, 0, 1'b1, "illegal_rand");
    do_reset();
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exec(BR, 1'b1, 0, 1'b1, "pre_mid_reset");
    memory_done = 1'b1; ir_opcode = BR; run = 1'b1; con_ff_bit = 1'b1;
    repeat (5) @(posedge Clock);
    #1;
    o = cur();
    n_tests++;
    if (o !== mk(C_BR4, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00)) begin
      n_fail++;
      $display("FAIL mid_reset_br4: got %h want %h", o, mk(C_BR4, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    end
    #1 clear_n = 1'b0;
    #1;
    o = cur();
    n_tests++;
    if (o !== mk(16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00)) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %h want all zero", o);
    end
    @(negedge Clock); clear_n = 1'b1;
`ifdef BRANCH_STATS_EN
    m_taken = 0; m_not = 0;
`endif
    @(posedge Clock); #1;
    o = cur();
    n_tests++;
    if (o !== mk(C_T0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00)) begin
      n_fail++;
      $display("FAIL mid_reset_T0: got %h want %h", o, mk(C_T0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    end
`ifdef BRANCH_STATS_EN
    n_tests++;
    if (taken_count !== 16'd0 || not_taken_count !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset_stats: got %0d/%0d want 0/0", taken_count, not_taken_count);
    end
`endif
    exec(BR, 1'b0, 0, 1'b1, "post_mid_reset");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_branch();
    test_nop();
    test_random();
    test_timeout();
    test_decode_traps();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
